// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: state encoding,
// occupancy width and performance counter width.
package pipe_pkg;

    localparam int OCC_W      = 2;
    localparam int PERF_CNT_W = 32;

    typedef logic [OCC_W-1:0] state_t;

    // State value doubles as the occupancy count.
    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_TWO   = 2'd2;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter, cleared by synchronous active-high reset.
// Ports: clk, reset, inc (count this cycle), count (current value).
module sat_cnt
    import pipe_pkg::*;
#(
    parameter int W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, flush and an
// optional 2-entry skid buffer (SKID=1) that makes in_ready a register.
// Ports: clk, reset (sync, active-high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (0..2).
// Macro PIPE_STAGE_PERF_EN adds stall_cnt and bubble_cnt outputs.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] bubble_cnt
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              rdy_q;
    logic              rdy_d;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else if (SKID != 0) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        main_d  = '0;
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end else begin
            if (in_fire) begin
                main_d  = in_data;
                state_d = ST_ONE;
            end else if (out_fire) begin
                main_d  = '0;
                state_d = ST_EMPTY;
            end
        end
    end

    // With a skid buffer, ready is decided one cycle ahead from the
    // next state; without one it only gates ready off during reset.
    always_comb begin
        rdy_d = 1'b1;
        if (SKID != 0) begin
            rdy_d = (state_d != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end

    // Outputs.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_q;
        occupancy = state_q;
        if (SKID != 0) begin
            in_ready = rdy_q;
        end else begin
            in_ready = rdy_q & (~out_valid | out_ready);
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    sat_cnt #(
        .W(PERF_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

    sat_cnt #(
        .W(PERF_CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (~out_valid),
        .count(bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: SKID=1 and SKID=0 instances,
// plus the perf counters when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

    logic        clk;
    logic        reset;

    logic        d_flush;
    logic        d_in_valid;
    logic        d_in_ready;
    logic [31:0] d_in_data;
    logic        d_out_valid;
    logic        d_out_ready;
    logic [31:0] d_out_data;
    logic [1:0]  d_occ;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] d_stall;
    logic [31:0] d_bubble;
    logic [31:0] s_stall;
    logic [31:0] s_bubble;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W(32),
        .SKID  (1)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (d_flush),
        .in_valid (d_in_valid),
        .in_ready (d_in_ready),
        .in_data  (d_in_data),
        .out_valid(d_out_valid),
        .out_ready(d_out_ready),
        .out_data (d_out_data),
        .occupancy(d_occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (d_stall),
        .bubble_cnt(d_bubble)
`endif
    );

    pipe_stage_skid #(
        .DATA_W(32),
        .SKID  (0)
    ) u_dut0 (
        .clk      (clk),
        .reset    (reset),
        .flush    (s_flush),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  (s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data (s_out_data),
        .occupancy(s_occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (s_stall),
        .bubble_cnt(s_bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        d_flush     = 1'b0;
        d_in_valid  = 1'b0;
        d_in_data   = '0;
        d_out_ready = 1'b1;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b1;

        // Reset state.
        tick();
        tick();
        chk("rst_valid", 64'(d_out_valid), 64'd0);
        chk("rst_occ", 64'(d_occ), 64'd0);
        chk("rst_data", 64'(d_out_data), 64'd0);
        chk("rst_ready", 64'(d_in_ready), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 64'(d_in_ready), 64'd1);

        // Back-to-back stream with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            d_in_valid = 1'b1;
            d_in_data  = 32'h11 + 32'(i);
            tick();
            chk("strm_valid", 64'(d_out_valid), 64'd1);
            chk("strm_data", 64'(d_out_data), 64'h11 + 64'(i));
            chk("strm_occ", 64'(d_occ), 64'd1);
            chk("strm_ready", 64'(d_in_ready), 64'd1);
        end
        d_in_valid = 1'b0;
        tick();
        chk("strm_drain", 64'(d_out_valid), 64'd0);
        chk("strm_occ0", 64'(d_occ), 64'd0);

        // Backpressure fills the skid buffer.
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_in_data   = 32'hA;
        tick();
        d_in_data = 32'hB;
        tick();
        chk("bp_occ", 64'(d_occ), 64'd2);
        chk("bp_ready", 64'(d_in_ready), 64'd0);
        chk("bp_data", 64'(d_out_data), 64'hA);
        d_in_data = 32'hD;
        tick();
        chk("bp_hold_data", 64'(d_out_data), 64'hA);
        chk("bp_hold_occ", 64'(d_occ), 64'd2);
        d_in_valid  = 1'b0;
        d_out_ready = 1'b1;
        tick();
        chk("drain_b", 64'(d_out_data), 64'hB);
        chk("drain_occ", 64'(d_occ), 64'd1);
        chk("drain_ready", 64'(d_in_ready), 64'd1);
        tick();
        chk("drain_empty", 64'(d_out_valid), 64'd0);
        chk("drain_zero", 64'(d_out_data), 64'd0);

        // Flush while full, with a pending input.
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_in_data   = 32'h1;
        tick();
        d_in_data = 32'h2;
        tick();
        chk("pre_flush_occ", 64'(d_occ), 64'd2);
        d_in_data = 32'hC;
        d_flush   = 1'b1;
        tick();
        d_flush    = 1'b0;
        d_in_valid = 1'b0;
        chk("flush_valid", 64'(d_out_valid), 64'd0);
        chk("flush_occ", 64'(d_occ), 64'd0);
        chk("flush_data", 64'(d_out_data), 64'd0);
        chk("flush_ready", 64'(d_in_ready), 64'd1);
        d_out_ready = 1'b1;
        tick();
        chk("flush_no_c", 64'(d_out_valid), 64'd0);

        // Flush in ONE drops a simultaneous accepted input.
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_in_data   = 32'h5;
        tick();
        d_in_data = 32'hC;
        d_flush   = 1'b1;
        tick();
        d_flush    = 1'b0;
        d_in_valid = 1'b0;
        chk("flush1_occ", 64'(d_occ), 64'd0);
        chk("flush1_data", 64'(d_out_data), 64'd0);

        // Reset mid-stream with two entries held.
        d_in_valid = 1'b1;
        d_in_data  = 32'h21;
        tick();
        d_in_data = 32'h22;
        tick();
        chk("pre_rst_occ", 64'(d_occ), 64'd2);
        d_in_data = 32'h23;
        reset     = 1'b1;
        tick();
        chk("mrst_valid", 64'(d_out_valid), 64'd0);
        chk("mrst_data", 64'(d_out_data), 64'd0);
        chk("mrst_occ", 64'(d_occ), 64'd0);
        chk("mrst_ready", 64'(d_in_ready), 64'd0);
        reset      = 1'b0;
        d_in_valid = 1'b0;
        tick();
        chk("mrst_ready1", 64'(d_in_ready), 64'd1);
        chk("mrst_occ1", 64'(d_occ), 64'd0);

        // SKID=0: combinational ready.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'h41;
        #1;
        chk("s0_ready_empty", 64'(s_in_ready), 64'd1);
        tick();
        chk("s0_load", 64'(s_out_data), 64'h41);
        s_in_data = 32'h42;
        #1;
        chk("s0_ready_stall", 64'(s_in_ready), 64'd0);
        tick();
        chk("s0_hold", 64'(s_out_data), 64'h41);
        chk("s0_hold_occ", 64'(s_occ), 64'd1);
        s_out_ready = 1'b1;
        #1;
        chk("s0_ready_pass", 64'(s_in_ready), 64'd1);
        tick();
        chk("s0_replace", 64'(s_out_data), 64'h42);
        chk("s0_replace_occ", 64'(s_occ), 64'd1);
        s_in_valid = 1'b0;
        tick();
        chk("s0_empty", 64'(s_out_valid), 64'd0);
        chk("s0_zero", 64'(s_out_data), 64'd0);
        chk("s0_occ0", 64'(s_occ), 64'd0);

`ifdef PIPE_STAGE_PERF_EN
        reset       = 1'b1;
        d_out_ready = 1'b0;
        tick();
        chk("pf_rst_stall", 64'(d_stall), 64'd0);
        chk("pf_rst_bubble", 64'(d_bubble), 64'd0);
        reset      = 1'b0;
        d_in_valid = 1'b1;
        d_in_data  = 32'h31;
        tick();
        tick();
        d_in_data = 32'h32;
        tick();
        d_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pf_stall5", 64'(d_stall), 64'd5);
        chk("pf_bubble2", 64'(d_bubble), 64'd2);
        d_out_ready = 1'b1;
        d_flush     = 1'b1;
        tick();
        d_flush = 1'b0;
        chk("pf_flush_stall", 64'(d_stall), 64'd5);
        tick();
        chk("pf_stall_kept", 64'(d_stall), 64'd5);
        chk("pf_bubble3", 64'(d_bubble), 64'd3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pf_clr_stall", 64'(d_stall), 64'd0);
        chk("pf_clr_bubble", 64'(d_bubble), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
